// File: rtl/humedad_pkg.sv
// Shared definitions for the humidity converter.
//   estado_t     : controller states
//   ADC_BITS     : raw sample width
//   BCD_DIGITOS  : packed BCD digits on the output
//   REDONDEO     : half-LSB rounding constant for the >>12 scaling
//   ITERACIONES  : double-dabble iterations (one per input bit)
package humedad_pkg;
  typedef enum logic [1:0] {INACTIVO, ESCALAR, CONVERTIR, HECHO} estado_t;

  localparam int ADC_BITS    = 12;
  localparam int BCD_DIGITOS = 3;
  localparam int REDONDEO    = 2048;
  localparam int ITERACIONES = 10;
  localparam int PCT_BITS    = 10;
  localparam int BCD_BITS    = 4 * BCD_DIGITOS;
  // Product width; exact for ESCALA up to 255 with a full-scale sample.
  localparam int PROD_BITS   = 20;
  localparam int SUMA_BITS   = 14;
endpackage

// File: rtl/bin_a_bcd.sv
// Serial shift-add-3 binary to BCD converter.
//   clk, rst : clock, synchronous active-high reset
//   start    : loads bin and begins ITERACIONES iterations
//   bin      : binary value, sampled when start=1
//   done     : high in the cycle whose rising edge commits the last iteration
//   bcd      : packed BCD result, final from the cycle after done
module bin_a_bcd
  import humedad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PCT_BITS-1:0] bin,
  output logic                done,
  output logic [BCD_BITS-1:0] bcd
);
  logic [PCT_BITS-1:0] sh;
  logic [BCD_BITS-1:0] acc;
  logic [3:0]          cnt;
  logic                activo;
  logic [BCD_BITS+PCT_BITS-1:0] tmp;

  function automatic logic [BCD_BITS-1:0] ajustar(input logic [BCD_BITS-1:0] b);
    logic [BCD_BITS-1:0] r;
    r = b;
    for (int d = 0; d < BCD_DIGITOS; d++)
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    return r;
  endfunction

  // Correct digits first, then shift the whole {bcd, bin} register left.
  assign tmp  = {ajustar(acc), sh};
  // Combinational so the controller can leave CONVERTIR on the same edge
  // that completes the last iteration.
  assign done = activo && (cnt == 4'(ITERACIONES - 1));
  assign bcd  = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      activo <= 1'b0;
    end else if (start) begin
      sh     <= bin;
      acc    <= '0;
      cnt    <= '0;
      activo <= 1'b1;
    end else if (activo) begin
      acc <= tmp[BCD_BITS+PCT_BITS-2 : PCT_BITS-1];
      sh  <= {tmp[PCT_BITS-2:0], 1'b0};
      cnt <= cnt + 4'd1;
      if (done) activo <= 1'b0;
    end
  end
endmodule

// File: rtl/conv_humedad.sv
// Humidity ADC sample to 3-digit BCD percentage converter.
// Optional macro HUMEDAD_PROMEDIO_EN enables a 4-sample moving average.
//   clk, rst   : clock, synchronous active-high reset
//   adc_dato   : raw 12-bit sample, valid with adc_valido
//   adc_valido : one-cycle strobe, only accepted when idle
//   humedad    : packed BCD result {hundreds, tens, units}
//   listo      : one-cycle pulse when humedad updates
//   ocupado    : conversion in progress
module conv_humedad
  import humedad_pkg::*;
#(
  parameter int ESCALA = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] adc_dato,
  input  logic                adc_valido,
  output logic [BCD_BITS-1:0] humedad,
  output logic                listo,
  output logic                ocupado
);
  estado_t estado, estado_sig;
  logic [ADC_BITS-1:0]  muestra, muestra_d;
  logic [PROD_BITS-1:0] producto;
  logic [PCT_BITS-1:0]  pct;
  logic [BCD_BITS-1:0]  bcd;
  logic aceptar, carga, pend, arrancar, fin;

  assign aceptar = (estado == INACTIVO) && adc_valido;
  assign ocupado = (estado != INACTIVO);

  assign producto = PROD_BITS'(muestra) * PROD_BITS'(ESCALA) + PROD_BITS'(REDONDEO);
  assign pct      = PCT_BITS'(producto >> ADC_BITS);

`ifdef HUMEDAD_PROMEDIO_EN
  // Window update happens in the first ESCALAR cycle (pend=1), which
  // stretches latency by one edge without a fifth state.
  logic [3:0][ADC_BITS-1:0] ventana;
  logic [SUMA_BITS-1:0]     suma, suma_nueva;
  logic [ADC_BITS-1:0]      nuevo;

  assign suma_nueva = suma - SUMA_BITS'(ventana[3]) + SUMA_BITS'(nuevo);
  assign carga      = pend;
  assign muestra_d  = suma_nueva[SUMA_BITS-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      ventana <= '0;
      suma    <= '0;
      nuevo   <= '0;
      pend    <= 1'b0;
    end else if (aceptar) begin
      nuevo <= adc_dato;
      pend  <= 1'b1;
    end else if (pend) begin
      ventana <= {ventana[2:0], nuevo};
      suma    <= suma_nueva;
      pend    <= 1'b0;
    end
  end
`else
  assign pend      = 1'b0;
  assign carga     = aceptar;
  assign muestra_d = adc_dato;
`endif

  bin_a_bcd u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (arrancar),
    .bin   (pct),
    .done  (fin),
    .bcd   (bcd)
  );

  always_comb begin
    estado_sig = estado;
    arrancar   = 1'b0;
    case (estado)
      INACTIVO:  if (adc_valido) estado_sig = ESCALAR;
      ESCALAR:   if (!pend) begin
                   arrancar   = 1'b1;
                   estado_sig = CONVERTIR;
                 end
      CONVERTIR: if (fin) estado_sig = HECHO;
      HECHO:     estado_sig = INACTIVO;
      default:   estado_sig = INACTIVO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado  <= INACTIVO;
      muestra <= '0;
      humedad <= '0;
      listo   <= 1'b0;
    end else begin
      estado <= estado_sig;
      listo  <= (estado == HECHO);
      if (carga) muestra <= muestra_d;
      if (estado == HECHO) humedad <= bcd;
    end
  end
endmodule
